// File: rtl/seq_pkg.sv
// Shared types and defaults for the 1101 pattern generator and detector benches.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} seq_state_e;

  localparam logic [3:0] DEF_PAT_1101 = 4'b1101;
  localparam int         SEQ_PAT_W    = 4;
  localparam int         SEQ_REP_W    = 8;
  localparam int         SEQ_GAP_W    = 4;
endpackage

// File: rtl/pat_shift_reg.sv
// Parallel-load pattern register with a descending bit index (MSB first).
module pat_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [PAT_W-1:0] pat,
  output logic             bit_out,
  output logic             first_bit,
  output logic             last_bit
);
  localparam int             IW  = $clog2(PAT_W);
  localparam logic [IW-1:0]  TOP = IW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q;
  logic [IW-1:0]    idx;

  // The index reloads to the MSB after bit 0, so the next repetition or
  // the bit after a gap always starts at the top without extra control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
      idx   <= '0;
    end else if (load) begin
      pat_q <= pat;
      idx   <= TOP;
    end else if (step) begin
      idx <= (idx == '0) ? TOP : idx - 1'b1;
    end
  end

  assign bit_out   = pat_q[idx];
  assign first_bit = (idx == TOP);
  assign last_bit  = (idx == '0);
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: R repetitions of a PAT_W-bit pattern, G zero bits between them.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter int               REP_W   = SEQ_REP_W,
  parameter int               GAP_W   = SEQ_GAP_W,
  parameter logic [PAT_W-1:0] DEF_PAT = DEF_PAT_1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [REP_W-1:0] reps_in,
  input  logic [GAP_W-1:0] gap_in,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             sof,
  output logic             busy,
  output logic             done
);
  seq_state_e       state;
  logic [REP_W-1:0] reps_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt;
  logic             load, step, bit_out, first_bit, last_bit;

  assign load = (state == IDLE) && start;
  assign step = (state == SHIFT);

  pat_shift_reg #(.PAT_W(PAT_W)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .pat       (use_def ? DEF_PAT : pat_in),
    .bit_out   (bit_out),
    .first_bit (first_bit),
    .last_bit  (last_bit)
  );

  // Outputs are registered from the current state, so they trail the
  // state register by one cycle: the bit shown after an edge is the one
  // the FSM was sitting on before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reps_q    <= '0;
      gap_q     <= '0;
      gcnt      <= '0;
      sdo       <= 1'b0;
      sdo_valid <= 1'b0;
      sof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          sof       <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            reps_q <= (reps_in == '0) ? REP_W'(1) : reps_in;
            gap_q  <= gap_in;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          sdo       <= bit_out;
          sdo_valid <= 1'b1;
          sof       <= first_bit;
          busy      <= 1'b1;
          done      <= 1'b0;
          if (last_bit) begin
            reps_q <= reps_q - 1'b1;
            if (reps_q > REP_W'(1)) begin
              if (gap_q != '0) begin
                gcnt  <= gap_q;
                state <= GAP;
              end
            end else begin
              state <= DONE;
            end
          end
        end
        GAP: begin
          sdo       <= 1'b0;
          sdo_valid <= 1'b1;
          sof       <= 1'b0;
          busy      <= 1'b1;
          done      <= 1'b0;
          gcnt      <= gcnt - 1'b1;
          if (gcnt == GAP_W'(1)) state <= SHIFT;
        end
        DONE: begin
          sdo       <= 1'b0;
          sdo_valid <= 1'b0;
          sof       <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench: per-cycle expected {sdo,sdo_valid,sof,busy,done} queued at start, popped after each edge.
module tb_seq_pattern_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       use_def = 1'b0;
  logic [3:0] pat_in = '0;
  logic [7:0] reps_in = '0;
  logic [3:0] gap_in = '0;
  logic       sdo, sdo_valid, sof, busy, done;

  int nvec = 0;
  int nerr = 0;
  logic [4:0] exp_q[$];

  seq_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .use_def   (use_def),
    .pat_in    (pat_in),
    .reps_in   (reps_in),
    .gap_in    (gap_in),
    .sdo       (sdo),
    .sdo_valid (sdo_valid),
    .sof       (sof),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {sdo, sdo_valid, sof, busy, done};
  endfunction

  task automatic cmp(input string tag, input logic [4:0] exp);
    logic [4:0] o;
    o = obs();
    nvec++;
    assert (o === exp) else begin
      nerr++;
      $error("FAIL %s: got {sdo,vld,sof,busy,done}=%b want %b", tag, o, exp);
    end
  endtask

  // Expected stream for one frame, built straight from the frame description.
  task automatic push_frame(input logic [3:0] pat, input int reps, input int gap);
    int r;
    r = (reps == 0) ? 1 : reps;
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, (b == 3), 1'b1, 1'b0});
      if (k < r - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(5'b01010);
    end
    exp_q.push_back(5'b00001);
  endtask

  task automatic check_n(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $error("FAIL %s: scoreboard empty, got %b want queued entry", tag, obs());
      end else cmp(tag, exp_q.pop_front());
    end
  endtask

  task automatic check_all(input string tag);
    check_n(tag, exp_q.size());
  endtask

  // Called at posedge+1; start is seen by the next edge.
  task automatic launch(input logic ud, input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    use_def = ud; pat_in = p; reps_in = r; gap_in = g; start = 1'b1;
    push_frame(ud ? 4'b1101 : p, int'(r), int'(g));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #3 cmp("reset_async", 5'b00000);
    repeat (2) @(posedge clk);
    #1 cmp("reset_held", 5'b00000);
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("idle", 5'b00000);

    launch(1'b1, 4'b0000, 8'd1, 4'd0);
    check_all("def_r1_g0");
    exp_q.push_back(5'b00000);
    check_n("def_r1_idle", 1);

    launch(1'b1, 4'b0000, 8'd2, 4'd0);
    check_all("def_r2_g0");

    launch(1'b0, 4'b1011, 8'd3, 4'd2);
    check_all("p1011_r3_g2");

    // reps=0 runs once; a mid-frame start with new inputs must be ignored
    launch(1'b0, 4'b0110, 8'd0, 4'd3);
    check_n("reps0", 1);
    start = 1'b1; pat_in = 4'b1001; reps_in = 8'd5; use_def = 1'b1;
    check_n("reps0_midstart", 1);
    start = 1'b0;
    check_all("reps0_tail");
    exp_q.push_back(5'b00000);
    check_n("reps0_no_restart", 1);

    // async reset during the third bit
    launch(1'b1, 4'b0000, 8'd4, 4'd1);
    check_n("rst_pre", 3);
    #2 rst = 1'b1;
    #1 cmp("rst_immediate", 5'b00000);
    exp_q.delete();
    @(posedge clk); #1;
    cmp("rst_hold", 5'b00000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(5'b00000);
    check_all("rst_no_done");
    launch(1'b0, 4'b1110, 8'd2, 4'd1);
    check_all("post_rst_frame");

    // start raised while the last bit is out, held through the done cycle
    launch(1'b0, 4'b1001, 8'd2, 4'd1);
    check_n("b2b_a", exp_q.size() - 1);
    start = 1'b1; use_def = 1'b0; pat_in = 4'b0111; reps_in = 8'd2; gap_in = 4'd0;
    check_n("b2b_a_done", 1);
    push_frame(4'b0111, 2, 0);
    @(posedge clk); #1;
    start = 1'b0;
    check_all("b2b_b");
    exp_q.push_back(5'b00000);
    check_n("b2b_idle", 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout, got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
